fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the 8-deep × 8-bit synchronous FIFO's write side (`wr`, `din`, `full`) among NUM_REQ producers. Each producer uses a valid/ready handshake. A granted producer owns the FIFO for a bounded burst, so one producer cannot starve the others. The block sits directly in front of the FIFO write port. The FIFO read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 14 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 31 +++
 rtl/fifo_wr_arbiter.sv | 93 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared types and defaults for the FIFO write-port arbiter
package fifo_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_BURST_MAX = 4;
    localparam int ID_W          = $clog2(DEF_NUM_REQ);

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// rr_pick: first set request at or above start, wrapping modulo N
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N = DEF_NUM_REQ
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    output logic                 found,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    logic [N-1:0] rot;
    logic [IW:0]  off;
    logic [IW:0]  sum;

    // rotate so bit 0 is the favoured index, then take the lowest set bit
    always_comb begin
        rot   = N'({req, req} >> start);
        found = |req;
        off   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) off = (IW + 1)'(i);
        end
        sum = {1'b0, start} + off;
        idx = (sum >= (IW + 1)'(N)) ? IW'(sum - (IW + 1)'(N)) : sum[IW-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin, burst-bounded sharing of a FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int BURST_MAX = DEF_BURST_MAX
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        full,
    output logic                        wr,
    output logic [DATA_W-1:0]           din,
    output logic                        grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id
);

    localparam int IW = $clog2(NUM_REQ);

    state_e             state_q, state_d;
    logic [IW-1:0]      owner_q, owner_d;
    logic [IW-1:0]      rr_q, rr_d;
    logic [3:0]         beat_q, beat_d;
    logic [IW-1:0]      nxt_ptr, pick_start, pick_idx;
    logic [NUM_REQ-1:0] own_bit, pick_req;
    logic               own, live, o_valid, o_last, burst_end, pick_found;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (pick_req),
        .start (pick_start),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // write-side datapath and burst termination; reset blocks any pending handshake
    always_comb begin
        own       = state_q == OWN;
        live      = own && rst;
        own_bit   = NUM_REQ'(1) << owner_q;
        o_valid   = req_valid[owner_q];
        o_last    = req_last[owner_q];
        wr        = live && o_valid && !full;
        req_ready = (live && !full) ? own_bit : '0;
        din       = req_data[owner_q*DATA_W +: DATA_W];
        burst_end = own && (!o_valid || (wr && (o_last || beat_q == 4'(BURST_MAX - 1))));
        nxt_ptr   = (owner_q == IW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        pick_req  = own ? (req_valid & ~own_bit) : req_valid;
        pick_start = own ? nxt_ptr : rr_q;
    end

    // grant FSM: take a winner from IDLE, hand over without a bubble at burst end
    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        rr_d    = rr_q;
        beat_d  = beat_q;
        if (!own) begin
            state_d = pick_found ? OWN : IDLE;
            owner_d = pick_found ? pick_idx : owner_q;
            beat_d  = '0;
        end else if (burst_end) begin
            rr_d    = nxt_ptr;
            state_d = pick_found ? OWN : IDLE;
            owner_d = pick_found ? pick_idx : owner_q;
            beat_d  = '0;
        end else if (wr) begin
            beat_d  = beat_q + 4'd1;
        end
    end

    // state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            rr_q    <= '0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            beat_q  <= beat_d;
        end
    end

    assign grant_valid = state_q == OWN;
    assign grant_id    = owner_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: randomized producers and FIFO against a behavioural arbiter model
module tb_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int BM = 4;

    logic              clk;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_last;
    logic [N*DW-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic              full;
    logic              wr;
    logic [DW-1:0]     din;
    logic              grant_valid;
    logic [1:0]        grant_id;

    fifo_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .BURST_MAX(BM)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .full        (full),
        .wr          (wr),
        .din         (din),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // model: current owner (-1 when none), favoured index, beats taken this burst
    int m_own = -1;
    int m_ptr = 0;
    int m_beats = 0;

    // producer heads: the beat each requester currently presents
    logic [DW-1:0] hd [N];
    logic [N-1:0]  hl;
    int fcnt = 0;
    int wcnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int start, input int excl, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int j;
            j = (start + k) % N;
            if (v[j] && j != excl) return j;
        end
        return -1;
    endfunction

    task automatic regen(input int i, input int lp);
        hd[i] = 8'($urandom);
        hl[i] = $urandom_range(99) < lp;
    endtask

    task automatic run_phase(input int len, input logic [N-1:0] mask, input int vp,
                             input int lp, input int fp, input int rp, input int sp);
        logic [N-1:0] acc;
        logic         w, rd, e_wr, fin;
        int           o;
        for (int c = 0; c < len; c++) begin
            rst  = !($urandom_range(99) < sp);
            rd   = $urandom_range(99) < rp;
            full = (fcnt == 8) || ($urandom_range(99) < fp);
            for (int i = 0; i < N; i++) begin
                req_valid[i] = mask[i] && ($urandom_range(99) < vp);
                req_last[i]  = hl[i];
                req_data[i*DW +: DW] = hd[i];
            end
            @(negedge clk);
            o    = (m_own < 0) ? 0 : m_own;
            e_wr = (m_own >= 0) && rst && req_valid[o] && !full;
            chk("wr", 32'(wr), 32'(e_wr));
            chk("ready", 32'(req_ready), ((m_own >= 0) && rst && !full) ? (32'd1 << o) : 32'd0);
            chk("gvalid", 32'(grant_valid), 32'(m_own >= 0));
            if (m_own >= 0) chk("gid", 32'(grant_id), 32'(m_own));
            if (e_wr) chk("din", 32'(din), 32'(hd[o]));
            acc = req_valid & req_ready;
            w   = wr;
            @(posedge clk);
            #1;
            if (!rst) begin
                m_own = -1;
                m_ptr = 0;
                m_beats = 0;
            end else if (m_own < 0) begin
                m_own = pick(m_ptr, -1, req_valid);
                m_beats = 0;
            end else begin
                fin = !req_valid[o] || (e_wr && (req_last[o] || m_beats + 1 == BM));
                if (e_wr) m_beats++;
                if (fin) begin
                    m_ptr = (o + 1) % N;
                    m_own = pick(m_ptr, o, req_valid);
                    m_beats = 0;
                end
            end
            for (int i = 0; i < N; i++) if (acc[i]) regen(i, lp);
            if (w) wcnt++;
            fcnt = fcnt + ((w && fcnt < 8) ? 1 : 0) - ((rd && fcnt > 0) ? 1 : 0);
        end
    endtask

    initial begin
        rst = 1'b0;
        full = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        for (int i = 0; i < N; i++) regen(i, 0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_gvalid", 32'(grant_valid), 32'd0);
        chk("rst_gid", 32'(grant_id), 32'd0);
        chk("rst_wr", 32'(wr), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        run_phase(40, 4'b0010, 100, 0, 0, 100, 0);
        run_phase(40, 4'b1111, 100, 100, 0, 100, 0);
        run_phase(60, 4'b0100, 100, 10, 30, 100, 0);
        run_phase(1500, 4'b1111, 70, 30, 15, 60, 2);
        run_phase(20, 4'b0000, 0, 0, 0, 100, 0);
        wcnt = 0;
        run_phase(30, 4'b0001, 100, 0, 0, 0, 0);
        chk("fill_cnt", 32'(fcnt), 32'd8);
        chk("fill_wr", 32'(wcnt), 32'd8);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
